teclado_emulador: RTL
=====================

# teclado_emulador

Synthesizable 4×4 matrix-keypad model, the row side of the keypad interface. It watches the column lines driven by the keypad scanner, pulls the matching row line low for a requested key, and adds programmable contact bounce. It is used on the board and in benches to press key sequences into the scanner → debounce → operand-capture path without a physical keypad.

## Interface
- `BOUNCE_CYC`, default 16: cycles of chatter on press and on release; 0 means no bounce phases.
- `GAP_CYC`, default 16: minimum open-contact cycles after release before `done`; 0 is treated as 1.
- `CNT_W`, default 16: width of `hold_cyc` and the internal counter.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `col` in 4: column lines from the scanner, active-low; several may be low at once.
- `fil` out 4: row lines to the scanner, active-low; idle value `4'b1111`.
- `req_valid` in 1: key-press request.
- `req_ready` out 1: high only in IDLE.
- `tecla` in 4: hex code of the key to press.
- `hold_cyc` in CNT_W: stable-closed duration in cycles; 0 is treated as 1.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the press/release sequence completes.

## Operation
- Key map (row,col):
  - 1(0,0) 2(0,1) 3(0,2) A(0,3)
  - 4(1,0) 5(1,1) 6(1,2) B(1,3)
  - 7(2,0) 8(2,1) 9(2,2) C(2,3)
  - E(3,0) 0(3,1) F(3,2) D(3,3)
  - Every 4-bit code maps to a key.
- Handshake: a request is accepted on a rising edge where `req_valid & req_ready`. On acceptance, the row, column and `max(hold_cyc,1)` are latched. `req_valid` is ignored while `busy`.
- Internal flag `contact` is registered. Row drive is combinational from it:
  - `fil[row] = ~(contact & ~col[c])`.
  - All other `fil` bits are 1.
  - With `contact=0`, `fil = 4'b1111`.
- States:
  - IDLE: `contact=0`. Goes to B_PRESS on acceptance, or to HOLD if `BOUNCE_CYC==0`.
  - B_PRESS: runs `BOUNCE_CYC` cycles with `contact = lfsr[0]`, then HOLD.
  - HOLD: runs `hold_cyc` cycles with `contact=1`, then B_REL (or GAP if `BOUNCE_CYC==0`).
  - B_REL: runs `BOUNCE_CYC` cycles with `contact = lfsr[0]`, then GAP.
  - GAP: runs `GAP_CYC` cycles with `contact=0`, then IDLE.
  - `done` is pulsed on the GAP→IDLE transition.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed `8'hA5` at reset.
  - Advances every cycle in B_PRESS/B_REL and holds otherwise.
  - The bounce pattern is deterministic after reset.
- Counter: a single down-counter reloaded at each state entry; it never wraps.

## Timing
- Reset values: `fil=4'b1111`, `req_ready=1`, `busy=0`, `done=0`, state IDLE, LFSR `8'hA5`.
- Reset in any state: next cycle is IDLE, `contact=0`, no `done`, request dropped.
- Acceptance edge at cycle t, with B=`BOUNCE_CYC`, H=hold, G=gap:
  - B_PRESS occupies t+1..t+B.
  - HOLD occupies t+B+1..t+B+H.
  - B_REL occupies t+B+H+1..t+2B+H.
  - GAP occupies t+2B+H+1..t+2B+H+G.
  - `done=1`, `req_ready=1` and `busy=0` at t+2B+H+G+1.
- A new request may be accepted in the same cycle `done` is high.
- `col` to `fil` path is zero latency, so the scanner sees a row response within the same cycle it drives a column.
- Column not driven (`col[c]=1`) during HOLD: `fil` stays `4'b1111`.

## Structure
- Package `teclado_pkg`:
  - State enum `teclado_emu_st_t`.
  - `FIL_IDLE = 4'b1111`, `LFSR_SEED = 8'hA5`.
  - Function `tecla_a_rc(code) -> {row[1:0], col[1:0]}`; the scanner's decode is its inverse.
- Sub-module `lfsr8` (ports `clk`, `rst`, `en`, `q[7:0]`); everything else in the top module.

## Test plan
- Reset, then drive `col = 4'b1110` rotating: `fil=4'b1111`, `req_ready=1`, `busy=0`.
- `BOUNCE_CYC=0`, request `tecla=4'h5`, `hold_cyc=10`; scanner rotates col, and `fil=4'b1101` only while `col=4'b1101` in HOLD; `done` exactly 10+G+1 cycles after acceptance.
- `BOUNCE_CYC=16`, `tecla=4'hD`, `hold_cyc=100`, `col=4'b0111` constant: `fil[3]` chatters for 16 cycles per LFSR from `8'hA5`, is low for 100, chatters 16, high for G; full scanner/debounce chain reports exactly one key D.
- `req_valid` held high with `tecla` 1,2,3 back-to-back: each accepted only when `req_ready`; three `done` pulses at the specified spacing; no overlap.
- `rst` asserted mid-HOLD: next cycle `fil=4'b1111`, `busy=0`, no `done`; next request runs normally with the LFSR restarted at `8'hA5`.
- `hold_cyc=0` and `GAP_CYC=0`: each treated as 1; sequence length 2B+2, `done` still single-cycle.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared types, constants and helpers for the keypad emulator.
package teclado_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B_PRESS,
        ST_HOLD,
        ST_B_REL,
        ST_GAP
    } teclado_emu_st_t;

    localparam logic [3:0] FIL_IDLE  = 4'b1111;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Hex key code to {row, col} position on the 4x4 matrix.
    function automatic logic [3:0] tecla_a_rc(input logic [3:0] code);
        logic [3:0] rc;
        case (code)
            4'h1:    rc = {2'd0, 2'd0};
            4'h2:    rc = {2'd0, 2'd1};
            4'h3:    rc = {2'd0, 2'd2};
            4'hA:    rc = {2'd0, 2'd3};
            4'h4:    rc = {2'd1, 2'd0};
            4'h5:    rc = {2'd1, 2'd1};
            4'h6:    rc = {2'd1, 2'd2};
            4'hB:    rc = {2'd1, 2'd3};
            4'h7:    rc = {2'd2, 2'd0};
            4'h8:    rc = {2'd2, 2'd1};
            4'h9:    rc = {2'd2, 2'd2};
            4'hC:    rc = {2'd2, 2'd3};
            4'hE:    rc = {2'd3, 2'd0};
            4'h0:    rc = {2'd3, 2'd1};
            4'hF:    rc = {2'd3, 2'd2};
            default: rc = {2'd3, 2'd3}; // 4'hD
        endcase
        return rc;
    endfunction

    // One Fibonacci step of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_paso(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/teclado_emulador_lfsr8.sv
// 8-bit bounce-pattern generator; advances only while enabled.
module lfsr8
    import teclado_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;

    // Restart from the fixed seed so the chatter pattern is reproducible.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= lfsr_paso(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/teclado_emulador.sv
// Row side of a 4x4 keypad: presses a requested key with contact bounce.
module teclado_emulador
    import teclado_pkg::*;
#(
    parameter int unsigned BOUNCE_CYC = 16,
    parameter int unsigned GAP_CYC    = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       col,
    output logic [3:0]       fil,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       tecla,
    input  logic [CNT_W-1:0] hold_cyc,
    output logic             busy,
    output logic             done
);

    // Counter reload values are "duration - 1"; zero durations collapse to one cycle.
    localparam int unsigned      B_M1       = (BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0;
    localparam int unsigned      G_M1       = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] B_LOAD     = CNT_W'(B_M1);
    localparam logic [CNT_W-1:0] G_LOAD     = CNT_W'(G_M1);
    localparam bit               HAS_BOUNCE = (BOUNCE_CYC != 0);

    teclado_emu_st_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_ld_q, hold_ld_in;
    logic [1:0]       row_q, colsel_q;
    logic             contact_q, contact_d;
    logic             done_q, done_d;
    logic [7:0]       lfsr_q, lfsr_nx;
    logic             lfsr_en;
    logic             accept;
    logic [3:0]       rc_in;

    assign rc_in      = tecla_a_rc(tecla);
    assign hold_ld_in = (hold_cyc == '0) ? '0 : hold_cyc - CNT_W'(1);
    assign accept     = (state_q == ST_IDLE) && req_valid;
    assign lfsr_en    = (state_q == ST_B_PRESS) || (state_q == ST_B_REL);

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (lfsr_en),
        .q   (lfsr_q)
    );

    // Value the LFSR will hold next cycle, so contact can be registered in step with it.
    assign lfsr_nx = lfsr_en ? lfsr_paso(lfsr_q) : lfsr_q;

    // State, counter, contact flag and the key latched at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            hold_ld_q <= '0;
            row_q     <= 2'd0;
            colsel_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            if (accept) begin
                hold_ld_q <= hold_ld_in;
                row_q     <= rc_in[3:2];
                colsel_q  <= rc_in[1:0];
            end
        end
    end

    // Sequence IDLE -> bounce -> hold -> bounce -> gap; counter reloads on every entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (HAS_BOUNCE) begin
                        state_d = ST_B_PRESS;
                        cnt_d   = B_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = hold_ld_in;
                    end
                end
            end
            ST_B_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = hold_ld_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = HAS_BOUNCE ? ST_B_REL : ST_GAP;
                    cnt_d   = HAS_BOUNCE ? B_LOAD : G_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_B_REL: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = G_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Contact follows the upcoming state; the row line is a zero-latency AND with the column.
    always_comb begin
        case (state_d)
            ST_B_PRESS, ST_B_REL: contact_d = lfsr_nx[0];
            ST_HOLD:              contact_d = 1'b1;
            default:              contact_d = 1'b0;
        endcase
        done_d          = (state_q == ST_GAP) && (cnt_q == '0);
        fil             = FIL_IDLE;
        fil[row_q]      = ~(contact_q & ~col[colsel_q]);
        req_ready       = (state_q == ST_IDLE);
        busy            = (state_q != ST_IDLE);
    end

    assign done = done_q;

endmodule
